// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Two-master round-robin arbiter in front of a single Wishbone classic slave.
// The winning master's address, write data and write-enable are registered
// and exactly one classic cycle is run on the slave. The completion (ACK, or
// ERR on timeout) is returned to the granted master only. A master that keeps
// its request asserted after completion is not re-issued until it drops CYC.
//
// Optional feature (compile-time macro):
//   WB_ARB_TIMEOUT_EN  - when defined, a BUSY-cycle counter aborts a slave
//                        cycle after TIMEOUT cycles without ACK_I and returns
//                        ERR to the granted master. When undefined, BUSY waits
//                        indefinitely and M0_ERR_O/M1_ERR_O stay 0.
//
// Parameters:
//   AW       address width
//   DW       data width
//   TIMEOUT  maximum BUSY cycles before ERR (timeout build only), >= 2
//
// Ports:
//   CLK_I, RST_NI                 clock (rising edge), async active-low reset
//   Mx_CYC_I/STB_I/WE_I           master x cycle, strobe, write-enable
//   Mx_ADR_I/DAT_I                master x address and write data
//   Mx_DAT_O                      master x read data (updated on its ACK)
//   Mx_ACK_O/ERR_O                master x one-cycle completion pulses
//   CYC_O/STB_O/WE_O              slave cycle, strobe, write-enable
//   ADR_O/DAT_O                   slave address and write data
//   DAT_I/ACK_I                   slave read data and acknowledge
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          CLK_I,
  input  logic          RST_NI,
  // master 0
  input  logic          M0_CYC_I,
  input  logic          M0_STB_I,
  input  logic          M0_WE_I,
  input  logic [AW-1:0] M0_ADR_I,
  input  logic [DW-1:0] M0_DAT_I,
  output logic [DW-1:0] M0_DAT_O,
  output logic          M0_ACK_O,
  output logic          M0_ERR_O,
  // master 1
  input  logic          M1_CYC_I,
  input  logic          M1_STB_I,
  input  logic          M1_WE_I,
  input  logic [AW-1:0] M1_ADR_I,
  input  logic [DW-1:0] M1_DAT_I,
  output logic [DW-1:0] M1_DAT_O,
  output logic          M1_ACK_O,
  output logic          M1_ERR_O,
  // slave
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  input  logic [DW-1:0] DAT_I,
  input  logic          ACK_I
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic          last_r;     // master granted most recently
  logic          gnt_r;      // master owning the current cycle
  logic          cyc_r;
  logic          stb_r;
  logic          we_r;
  logic [AW-1:0] adr_r;
  logic [DW-1:0] dat_r;
  logic [DW-1:0] m0_dat_r;
  logic [DW-1:0] m1_dat_r;
  logic          m0_ack_r;
  logic          m1_ack_r;
  logic          m0_err_r;
  logic          m1_err_r;

  logic          req0_s;
  logic          req1_s;
  logic          any_req_s;
  logic          gnt_sel_s;
  logic          gnt_cyc_s;
  logic          tmo_hit_s;

  assign req0_s    = M0_CYC_I & M0_STB_I;
  assign req1_s    = M1_CYC_I & M1_STB_I;
  assign any_req_s = req0_s | req1_s;
  // DONE/abort decisions only look at the owner's CYC, never the other master
  assign gnt_cyc_s = gnt_r ? M1_CYC_I : M0_CYC_I;

  // Round-robin pick: on a tie the master that did not win last time goes
  always_comb begin
    gnt_sel_s = 1'b0;
    if (req0_s && req1_s) begin
      gnt_sel_s = ~last_r;
    end else if (req1_s) begin
      gnt_sel_s = 1'b1;
    end else begin
      gnt_sel_s = 1'b0;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_r;

  // Count BUSY cycles; held at zero outside BUSY so every entry starts fresh
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_BUSY) begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end else begin
      tmo_cnt_r <= {CW{1'b0}};
    end
  end

  // Count TIMEOUT-1 marks the last permitted BUSY cycle
  assign tmo_hit_s = (tmo_cnt_r == CW'(TIMEOUT - 1));
`else
  assign tmo_hit_s = 1'b0;

  // TIMEOUT only matters in the timeout build; keep it referenced here
  if (TIMEOUT < 2) begin : g_tmo_unused
  end
`endif

  // Arbitration FSM with all bus outputs registered
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_r  <= ST_IDLE;
      last_r   <= 1'b1;
      gnt_r    <= 1'b0;
      cyc_r    <= 1'b0;
      stb_r    <= 1'b0;
      we_r     <= 1'b0;
      adr_r    <= {AW{1'b0}};
      dat_r    <= {DW{1'b0}};
      m0_dat_r <= {DW{1'b0}};
      m1_dat_r <= {DW{1'b0}};
      m0_ack_r <= 1'b0;
      m1_ack_r <= 1'b0;
      m0_err_r <= 1'b0;
      m1_err_r <= 1'b0;
    end else begin
      // completion strobes are single-cycle pulses
      m0_ack_r <= 1'b0;
      m1_ack_r <= 1'b0;
      m0_err_r <= 1'b0;
      m1_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r <= ST_BUSY;
            gnt_r   <= gnt_sel_s;
            last_r  <= gnt_sel_s;
            cyc_r   <= 1'b1;
            stb_r   <= 1'b1;
            if (gnt_sel_s) begin
              adr_r <= M1_ADR_I;
              dat_r <= M1_DAT_I;
              we_r  <= M1_WE_I;
            end else begin
              adr_r <= M0_ADR_I;
              dat_r <= M0_DAT_I;
              we_r  <= M0_WE_I;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // ACK has priority, so an ACK on the final timeout cycle still wins
          if (ACK_I) begin
            state_r <= ST_DONE;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            if (gnt_r) begin
              m1_dat_r <= DAT_I;
              m1_ack_r <= 1'b1;
            end else begin
              m0_dat_r <= DAT_I;
              m0_ack_r <= 1'b1;
            end
          end else if (!gnt_cyc_s) begin
            // master abort: silent return to IDLE, pointer keeps this grant
            state_r <= ST_IDLE;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
          end else if (tmo_hit_s) begin
            state_r <= ST_DONE;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            if (gnt_r) begin
              m1_err_r <= 1'b1;
            end else begin
              m0_err_r <= 1'b1;
            end
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_DONE: begin
          // wait for the owner to drop CYC so a held request is not re-run
          if (!gnt_cyc_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
        end
      endcase
    end
  end

  assign CYC_O    = cyc_r;
  assign STB_O    = stb_r;
  assign WE_O     = we_r;
  assign ADR_O    = adr_r;
  assign DAT_O    = dat_r;
  assign M0_DAT_O = m0_dat_r;
  assign M1_DAT_O = m1_dat_r;
  assign M0_ACK_O = m0_ack_r;
  assign M1_ACK_O = m1_ack_r;
  assign M0_ERR_O = m0_err_r;
  assign M1_ERR_O = m1_err_r;

endmodule
